// File: rtl/conv_pkg.sv
// conv_pkg: defaults, FSM state type and window-count helpers shared by the
// 3x3 window generator and its frame buffer.
// Optional feature macro: WINGEN_ZERO_PAD_EN ("same" padding; the anchor is
// the window centre and out-of-map taps read as zero).
package conv_pkg;

    localparam int WI_DEF    = 8;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int NPASS_DEF = 4;

    typedef enum logic {
        LOAD = 1'b0,
        SCAN = 1'b1
    } wingen_state_e;

    // Number of windows emitted in one pass over the stored map.
    function automatic int win_per_pass(input int img_w, input int img_h);
`ifdef WINGEN_ZERO_PAD_EN
        return img_w * img_h;
`else
        return (img_w - 2) * (img_h - 2);
`endif
    endfunction

    // Anchor positions per row of the anchor grid.
    function automatic int anchor_cols(input int img_w);
`ifdef WINGEN_ZERO_PAD_EN
        return img_w;
`else
        return img_w - 2;
`endif
    endfunction

    // Offset from anchor to the top-left tap (1 when the anchor is the centre).
    function automatic int tap_offset();
`ifdef WINGEN_ZERO_PAD_EN
        return 1;
`else
        return 0;
`endif
    endfunction

endpackage

// File: rtl/conv_frame_buf.sv
// conv_frame_buf: single-write-port register array holding one feature map,
// with three combinational row-read ports. Each read port returns three
// horizontally contiguous pixels starting at (row, col), leftmost in the MSBs.
// Coordinates may be wrapped "minus one" values or one past the edge; such
// taps return an arbitrary stored pixel and are masked by the caller.
module conv_frame_buf
    import conv_pkg::*;
#(
    parameter int WI    = WI_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = $clog2(IMG_W * IMG_H),
    parameter int RW    = $clog2(IMG_H + 1),
    parameter int CW    = $clog2(IMG_W + 1)
) (
    input  logic                 iClk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [WI-1:0] wr_data,
    input  logic [2:0][RW-1:0]   rd_row,
    input  logic [CW-1:0]        rd_col,
    output logic [2:0][3*WI-1:0] rd_data
);

    localparam int NPIX = IMG_W * IMG_H;

    logic signed [WI-1:0] mem [NPIX];

    // Out-of-map coordinates fold onto address 0 so the array is never
    // indexed past its end.
    function automatic logic [WI-1:0] rd_pix(input logic [RW-1:0] row,
                                             input logic [CW-1:0] col);
        logic [AW-1:0] addr;
        addr = '0;
        if ((int'(row) < IMG_H) && (int'(col) < IMG_W))
            addr = AW'(int'(row) * IMG_W + int'(col));
        return mem[addr];
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_tap
            assign rd_data[i][(2-j)*WI +: WI] = rd_pix(rd_row[i], rd_col + CW'(j));
        end
    end

    // Frame store write port; contents survive reset.
    always_ff @(posedge iClk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen: loads one raster feature map into a frame buffer, then
// replays every 3x3 window NPASS times back to back, flagging the last window
// of each pass (oMapDone) and of the frame (oFrameDone).
// Optional feature macro: WINGEN_ZERO_PAD_EN ("same" padding).
// Pipeline: _p0 is the registered anchor counter, _p1 the registered outputs.
module conv3x3_window_gen
    import conv_pkg::*;
#(
    parameter int WI    = WI_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int NPASS = NPASS_DEF
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iPixValid,
    input  logic signed [WI-1:0] iPixData,
    output logic                 oPixReady,
    output logic                 oWindowValid,
    output logic [3*WI-1:0]      oWindowInRow1,
    output logic [3*WI-1:0]      oWindowInRow2,
    output logic [3*WI-1:0]      oWindowInRow3,
    output logic                 oMapDone,
    output logic                 oFrameDone
);

    localparam int NPIX    = IMG_W * IMG_H;
    localparam int AW      = $clog2(NPIX);
    localparam int RW      = $clog2(IMG_H + 1);
    localparam int CW      = $clog2(IMG_W + 1);
    localparam int WPP     = win_per_pass(IMG_W, IMG_H);
    localparam int WNW     = (WPP > 1) ? $clog2(WPP) : 1;
    localparam int PW      = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int TAP_OFF = tap_offset();
    localparam int C_LAST  = anchor_cols(IMG_W) - 1;

    wingen_state_e state_q, state_d;

    logic [AW-1:0]  waddr_q;
    logic           pix_acc;
    logic           load_last;

    logic           vld_p0;
    logic [RW-1:0]  row_p0;
    logic [CW-1:0]  col_p0;
    logic [WNW-1:0] win_p0;
    logic [PW-1:0]  pass_p0;
    logic           last_win;
    logic           last_pass;

    logic [2:0][RW-1:0]   rd_row;
    logic [CW-1:0]        rd_col;
    logic [2:0][3*WI-1:0] rd_data;
    logic [2:0][3*WI-1:0] win_rows_d;

    logic                 vld_p1;
    logic                 map_done_p1;
    logic                 frame_done_p1;
    logic [2:0][3*WI-1:0] win_rows_p1;

    assign oPixReady = (state_q == LOAD) & ~iRst;
    assign pix_acc   = iPixValid & oPixReady;
    assign load_last = pix_acc && (waddr_q == AW'(NPIX - 1));
    assign last_win  = vld_p0 && (win_p0 == WNW'(WPP - 1));
    assign last_pass = (pass_p0 == PW'(NPASS - 1));

    // FSM state register.
    always_ff @(posedge iClk) begin
        if (iRst)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // FSM next state: SCAN is left once the frame-done window has been
    // presented, so the loader only reopens after the final window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (load_last)     state_d = SCAN;
            SCAN:    if (frame_done_p1) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Load address: raster position of the next accepted pixel.
    always_ff @(posedge iClk) begin
        if (iRst)
            waddr_q <= '0;
        else if (pix_acc)
            waddr_q <= load_last ? '0 : waddr_q + AW'(1);
    end

    conv_frame_buf #(
        .WI    (WI),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW),
        .RW    (RW),
        .CW    (CW)
    ) u_frame_buf (
        .iClk    (iClk),
        .wr_en   (pix_acc),
        .wr_addr (waddr_q),
        .wr_data (iPixData),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data (rd_data)
    );

    // ---- stage p0: anchor counter ----
    // Anchor stepping: one idle cycle on entry to SCAN, then one anchor per
    // cycle across all passes with no gaps; idle again on the tail cycle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            vld_p0  <= 1'b0;
            row_p0  <= '0;
            col_p0  <= '0;
            win_p0  <= '0;
            pass_p0 <= '0;
        end else if (load_last) begin
            vld_p0  <= 1'b0;
            row_p0  <= '0;
            col_p0  <= '0;
            win_p0  <= '0;
            pass_p0 <= '0;
        end else if (state_q == SCAN) begin
            if (!vld_p0) begin
                vld_p0 <= !frame_done_p1;
            end else if (last_win) begin
                row_p0 <= '0;
                col_p0 <= '0;
                win_p0 <= '0;
                if (last_pass) begin
                    pass_p0 <= '0;
                    vld_p0  <= 1'b0;
                end else begin
                    pass_p0 <= pass_p0 + PW'(1);
                end
            end else begin
                win_p0 <= win_p0 + WNW'(1);
                if (col_p0 == CW'(C_LAST)) begin
                    col_p0 <= '0;
                    row_p0 <= row_p0 + RW'(1);
                end else begin
                    col_p0 <= col_p0 + CW'(1);
                end
            end
        end
    end

    // Buffer read coordinates for the three tap rows; a -1 wraps to all-ones,
    // which the buffer treats as out of map.
    always_comb begin
        for (int i = 0; i < 3; i++)
            rd_row[i] = row_p0 + RW'(i) - RW'(TAP_OFF);
        rd_col = col_p0 - CW'(TAP_OFF);
    end

    // Window assembly, zeroing taps that fall outside the map when padding.
    always_comb begin
        win_rows_d = rd_data;
`ifdef WINGEN_ZERO_PAD_EN
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if ((i == 0 && row_p0 == '0) ||
                    (i == 2 && row_p0 == RW'(IMG_H - 1)) ||
                    (j == 0 && col_p0 == '0) ||
                    (j == 2 && col_p0 == CW'(IMG_W - 1)))
                    win_rows_d[i][(2-j)*WI +: WI] = '0;
            end
        end
`endif
    end

    // ---- stage p1: registered window outputs and pass pulses ----
    // Rows hold their last window while idle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            vld_p1        <= 1'b0;
            map_done_p1   <= 1'b0;
            frame_done_p1 <= 1'b0;
            win_rows_p1   <= '0;
        end else begin
            vld_p1        <= vld_p0;
            map_done_p1   <= last_win;
            frame_done_p1 <= last_win && last_pass;
            if (vld_p0)
                win_rows_p1 <= win_rows_d;
        end
    end

    assign oWindowValid  = vld_p1;
    assign oMapDone      = map_done_p1;
    assign oFrameDone    = frame_done_p1;
    assign oWindowInRow1 = win_rows_p1[0];
    assign oWindowInRow2 = win_rows_p1[1];
    assign oWindowInRow3 = win_rows_p1[2];

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// tb_conv3x3_window_gen: randomized self-checking bench for the 3x3 window
// generator on a 5x5 map with 4 passes. Window contents are predicted from a
// plain pixel array indexed by anchor and tap offset.
module tb_conv3x3_window_gen;

    localparam int WI    = 8;
    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
    localparam int NPASS = 4;
    localparam int NPIX  = IMG_W * IMG_H;
`ifdef WINGEN_ZERO_PAD_EN
    localparam int OFF   = 1;
    localparam int ACOLS = IMG_W;
    localparam int AROWS = IMG_H;
`else
    localparam int OFF   = 0;
    localparam int ACOLS = IMG_W - 2;
    localparam int AROWS = IMG_H - 2;
`endif
    localparam int WPP = ACOLS * AROWS;

    logic                 iClk = 1'b0;
    logic                 iRst;
    logic                 iPixValid;
    logic signed [WI-1:0] iPixData;
    logic                 oPixReady;
    logic                 oWindowValid;
    logic [3*WI-1:0]      oWindowInRow1;
    logic [3*WI-1:0]      oWindowInRow2;
    logic [3*WI-1:0]      oWindowInRow3;
    logic                 oMapDone;
    logic                 oFrameDone;

    int n_chk;
    int n_pass;

    logic [WI-1:0]   img [NPIX];
    logic [3*WI-1:0] first_r1, first_r2, first_r3;
    logic [3*WI-1:0] last_r1, last_r2, last_r3;

    conv3x3_window_gen #(
        .WI    (WI),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .NPASS (NPASS)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iPixValid     (iPixValid),
        .iPixData      (iPixData),
        .oPixReady     (oPixReady),
        .oWindowValid  (oWindowValid),
        .oWindowInRow1 (oWindowInRow1),
        .oWindowInRow2 (oWindowInRow2),
        .oWindowInRow3 (oWindowInRow3),
        .oMapDone      (oMapDone),
        .oFrameDone    (oFrameDone)
    );

    always #5 iClk = ~iClk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Expected packed tap row i of window number win within a pass.
    function automatic logic [3*WI-1:0] exp_row(input int win, input int i);
        int ar, ac, rr, cc;
        logic [3*WI-1:0] v;
        logic [WI-1:0] pix;
        ar = win / ACOLS;
        ac = win % ACOLS;
        v  = '0;
        for (int j = 0; j < 3; j++) begin
            rr = ar + i - OFF;
            cc = ac + j - OFF;
            if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
                pix = img[rr * IMG_W + cc];
            else
                pix = '0;
            v = {v[2*WI-1:0], pix};
        end
        return v;
    endfunction

    task automatic drive_junk(input bit junk);
        if (junk) begin
            iPixValid = 1'($urandom_range(0, 1));
            iPixData  = WI'($urandom);
        end else begin
            iPixValid = 1'b0;
        end
    endtask

    // gap_mode: 0 valid held, 1 toggling 1,0,1,0, 2 random gaps.
    // pat: 0 idx, 1 100+idx, 2 random.
    task automatic load_frame(input int n, input int gap_mode, input int pat);
        int idx, guard;
        logic [WI-1:0] px;
        logic v;
        bit tog;
        idx = 0; guard = 0; tog = 1'b1;
        while (idx < n && guard < 20 * NPIX) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            case (pat)
                0:       px = WI'(idx);
                1:       px = WI'(100 + idx);
                default: px = WI'($urandom);
            endcase
            iPixValid = v;
            iPixData  = px;
            check_val("load_ready", oPixReady, 1);
            @(posedge iClk); #1;
            if (v) begin
                img[idx] = px;
                idx++;
            end
            guard++;
        end
        iPixValid = 1'b0;
        check_val("load_count", idx, n);
    endtask

    // Called right after the edge accepting the last pixel.
    task automatic check_scan(input bit junk);
        int md;
        md = 0;
        drive_junk(junk);
        @(posedge iClk); #1;
        check_val("lat_k1_valid", oWindowValid, 0);
        check_val("lat_k1_ready", oPixReady, 0);
        drive_junk(junk);
        @(posedge iClk); #1;
        for (int p = 0; p < NPASS; p++) begin
            for (int w = 0; w < WPP; w++) begin
                check_val("win_valid", oWindowValid, 1);
                check_val("win_row1", oWindowInRow1, exp_row(w, 0));
                check_val("win_row2", oWindowInRow2, exp_row(w, 1));
                check_val("win_row3", oWindowInRow3, exp_row(w, 2));
                check_val("map_done", oMapDone, (w == WPP - 1));
                check_val("frame_done", oFrameDone, (w == WPP - 1) && (p == NPASS - 1));
                check_val("scan_ready", oPixReady, 0);
                if (oMapDone) md++;
                if (p == 0 && w == 0) begin
                    first_r1 = oWindowInRow1; first_r2 = oWindowInRow2; first_r3 = oWindowInRow3;
                end
                if (p == 0 && w == WPP - 1) begin
                    last_r1 = oWindowInRow1; last_r2 = oWindowInRow2; last_r3 = oWindowInRow3;
                end
                drive_junk(junk);
                @(posedge iClk); #1;
            end
        end
        iPixValid = 1'b0;
        check_val("post_valid", oWindowValid, 0);
        check_val("post_ready", oPixReady, 1);
        check_val("map_done_count", md, NPASS);
    endtask

    task automatic reset_pulse();
        iPixValid = 1'b0;
        iRst = 1'b1;
        #1;
        check_val("rst_ready_low", oPixReady, 0);
        @(posedge iClk); #1;
        iRst = 1'b0;
        #1;
        check_val("rst_valid", oWindowValid, 0);
        check_val("rst_map_done", oMapDone, 0);
        check_val("rst_frame_done", oFrameDone, 0);
        check_val("rst_row1", oWindowInRow1, 0);
        check_val("rst_ready", oPixReady, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0;
        iRst = 1'b1; iPixValid = 1'b0; iPixData = '0;
        repeat (3) @(posedge iClk);
        #1;
        check_val("reset_valid", oWindowValid, 0);
        check_val("reset_map_done", oMapDone, 0);
        check_val("reset_frame_done", oFrameDone, 0);
        check_val("reset_row1", oWindowInRow1, 0);
        check_val("reset_row2", oWindowInRow2, 0);
        check_val("reset_row3", oWindowInRow3, 0);
        check_val("reset_ready", oPixReady, 0);
        iRst = 1'b0;
        #1;
        check_val("ready_after_reset", oPixReady, 1);

        // Frame of r*5+c, valid held high.
        load_frame(NPIX, 0, 0);
        check_scan(1'b0);
`ifdef WINGEN_ZERO_PAD_EN
        check_val("plan_first_r1", first_r1, 24'h000000);
        check_val("plan_first_r2", first_r2, 24'h000001);
        check_val("plan_first_r3", first_r3, 24'h000506);
        check_val("plan_last_r1", last_r1, 24'h121300);
        check_val("plan_last_r2", last_r2, 24'h171800);
        check_val("plan_last_r3", last_r3, 24'h000000);
`else
        check_val("plan_first_r1", first_r1, 24'h000102);
        check_val("plan_first_r2", first_r2, 24'h050607);
        check_val("plan_first_r3", first_r3, 24'h0A0B0C);
        check_val("plan_last_r1", last_r1, 24'h0C0D0E);
        check_val("plan_last_r2", last_r2, 24'h111213);
        check_val("plan_last_r3", last_r3, 24'h161718);
`endif

        // Same frame with toggling valid, junk pixels driven during the scan.
        load_frame(NPIX, 1, 0);
        check_scan(1'b1);
`ifdef WINGEN_ZERO_PAD_EN
        check_val("gap_first_r2", first_r2, 24'h000001);
`else
        check_val("gap_first_r1", first_r1, 24'h000102);
`endif

        // Second frame of 100+idx with random gaps.
        load_frame(NPIX, 2, 1);
        check_scan(1'b1);
`ifdef WINGEN_ZERO_PAD_EN
        check_val("frame2_first_r2", first_r2, 24'h006465);
`else
        check_val("frame2_first_r1", first_r1, 24'h646566);
`endif

        // Reset part-way through a load, then a full random frame.
        load_frame(7, 2, 2);
        reset_pulse();
        load_frame(NPIX, 2, 2);
        check_scan(1'b1);

        // Reset during pass 2 of a random frame, then a fresh full frame.
        load_frame(NPIX, 0, 2);
        repeat (2 + 2 * WPP + 3) begin
            drive_junk(1'b1);
            @(posedge iClk); #1;
        end
        reset_pulse();
        repeat (5) begin
            @(posedge iClk); #1;
            check_val("idle_valid", oWindowValid, 0);
            check_val("idle_map_done", oMapDone, 0);
        end
        load_frame(NPIX, 2, 2);
        check_scan(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
